wave_capture: RTL and testbench

//  Triggered waveform recorder: the write-side counterpart of the sine-ROM address sweeper.

---
 rtl/wave_capture.sv | 152 +++++++++++++++
 tb/tb_wave_capture.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/wave_capture.sv
// Triggered waveform recorder. It waits for a rising crossing of trig_level
// on the incoming sample stream, or for a forced trigger. It then stores
// DEPTH consecutive valid samples in a simple dual-port RAM, starting at
// address 0. The stored samples are read back through a registered read port.
module wave_capture #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              force_trig,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic                prev_valid_q, prev_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   rd_data_q;

    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic                cross_s;

    // Storage only: no reset, one write port and one read port on the same clock.
    logic [DATA_W-1:0]   mem_r [0:DEPTH-1];

    // A rising level crossing occurs when the previous sample was below the
    // threshold and the current sample is at or above it.
    assign cross_s = (prev_q < trig_level) && (din >= trig_level);

    // Next-state, write-enable and trigger-history computation.
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        mem_we_s     = 1'b0;
        mem_waddr_s  = wr_addr_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d      = ST_ARMED;
                    prev_valid_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ARMED: begin
                if (din_valid) begin
                    prev_d       = din;
                    prev_valid_d = 1'b1;
                    // The first valid sample after arm only seeds the history.
                    if (prev_valid_q && (cross_s || force_trig)) begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = {ADDR_W{1'b0}};
                        wr_addr_d   = {{(ADDR_W-1){1'b0}}, 1'b1};
                        state_d     = ST_CAPTURE;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                if (din_valid) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = wr_addr_q;
                    wr_addr_d   = wr_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (wr_addr_q == {ADDR_W{1'b1}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A write is suppressed in a reset cycle so that reset leaves RAM alone.
        if (rst) begin
            mem_we_s = 1'b0;
        end else begin
            mem_we_s = mem_we_s;
        end
        // Outputs are registered from the next state, so they decode the current state.
        busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_addr_q    <= {ADDR_W{1'b0}};
            prev_q       <= {DATA_W{1'b0}};
            prev_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // RAM write port. Its contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= din;
        end
    end

    // Registered read port. A read of the address being written returns the old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= {DATA_W{1'b0}};
        end else begin
            rd_data_q <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture. It compares the RAM contents against a
// scoreboard of hand-derived values, and it checks busy and done at the
// capture boundaries.
module tb_wave_capture;

    logic       clk;
    logic       rst;
    logic       arm;
    logic       force_trig;
    logic [7:0] trig_level;
    logic [7:0] din;
    logic       din_valid;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb [0:255];

    wave_capture #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .force_trig (force_trig),
        .trig_level (trig_level),
        .din        (din),
        .din_valid  (din_valid),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; outputs are then examined 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic feed(input logic [7:0] v);
        din       = v;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    task automatic readback(input string tag);
        int errs_before;
        errs_before = n_errors;
        din_valid = 1'b0;
        for (int a = 0; a < 256; a++) begin
            rd_addr = a[7:0];
            step();
            check_val(tag, {24'd0, rd_data}, {24'd0, sb[a]});
            if (n_errors > errs_before + 4) begin
                a = 256;
            end
        end
    endtask

    task automatic ramp_sb();
        for (int k = 0; k < 256; k++) begin
            sb[k] = 8'(128 + k);
        end
    endtask

    initial begin
        int idx;
        int cyc;
        rst = 1'b1; arm = 1'b0; force_trig = 1'b0; trig_level = 8'd128;
        din = 8'd0; din_valid = 1'b0; rd_addr = 8'd0;

        // Test 1: reset held two cycles with random inputs.
        for (int i = 0; i < 2; i++) begin
            arm = 1'($urandom_range(0, 1)); din = 8'($urandom_range(0, 255));
            din_valid = 1'($urandom_range(0, 1)); force_trig = 1'($urandom_range(0, 1));
            rd_addr = 8'($urandom_range(0, 255));
            step();
        end
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_rdata", {24'd0, rd_data}, 32'd0);
        rst = 1'b0; arm = 1'b0; force_trig = 1'b0; din_valid = 1'b0;
        feed(8'd0); feed(8'd200); feed(8'd250);
        check_val("noarm_busy", {31'd0, busy}, 32'd0);

        // Test 2: continuous ramp, trigger at 128.
        trig_level = 8'd128;
        pulse_arm();
        check_val("t2_armed_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 384; i++) begin
            if (i == 383) begin
                check_val("t2_pre_done", {31'd0, done}, 32'd0);
                check_val("t2_pre_busy", {31'd0, busy}, 32'd1);
            end
            din = i[7:0]; din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        check_val("t2_done", {31'd0, done}, 32'd1);
        check_val("t2_busy", {31'd0, busy}, 32'd0);
        ramp_sb();
        readback("t2_mem");

        // Test 3: no trigger on 200, 200, 50; trigger on 130.
        trig_level = 8'd100;
        pulse_arm();
        feed(8'd200); feed(8'd200); feed(8'd50);
        check_val("t3_waiting", {31'd0, busy}, 32'd1);
        feed(8'd130);
        for (int k = 1; k < 256; k++) begin
            if (k == 255) check_val("t3_pre_done", {31'd0, done}, 32'd0);
            feed(k[7:0]);
        end
        check_val("t3_done", {31'd0, done}, 32'd1);
        sb[0] = 8'd130;
        for (int k = 1; k < 256; k++) sb[k] = k[7:0];
        readback("t3_mem");

        // Test 4: ramp with random gaps in din_valid.
        trig_level = 8'd128;
        pulse_arm();
        idx = 0; cyc = 0;
        while (idx < 384 && cyc < 4000) begin
            din_valid = 1'($urandom_range(0, 1));
            din = idx[7:0];
            if (din_valid && idx == 383) check_val("t4_pre_done", {31'd0, done}, 32'd0);
            step();
            if (din_valid) idx++;
            cyc++;
        end
        din_valid = 1'b0;
        check_val("t4_budget", idx, 32'd384);
        check_val("t4_done", {31'd0, done}, 32'd1);
        ramp_sb();
        readback("t4_mem");

        // Test 5: the forced trigger fires on the second valid sample.
        force_trig = 1'b1;
        pulse_arm();
        for (int n = 1; n <= 257; n++) begin
            if (n == 257) check_val("t5_pre_done", {31'd0, done}, 32'd0);
            feed(8'd7);
        end
        force_trig = 1'b0;
        check_val("t5_done", {31'd0, done}, 32'd1);
        for (int k = 0; k < 256; k++) sb[k] = 8'd7;
        readback("t5_mem");

        // Test 6: arm mid-capture is ignored, re-arm from DONE, reset mid-capture.
        trig_level = 8'd128;
        pulse_arm();
        for (int i = 0; i < 384; i++) begin
            arm = (i == 200);
            if (i == 383) check_val("t6_pre_done", {31'd0, done}, 32'd0);
            din = i[7:0]; din_valid = 1'b1;
            step();
        end
        arm = 1'b0; din_valid = 1'b0;
        check_val("t6_done", {31'd0, done}, 32'd1);
        pulse_arm();
        check_val("t6_rearm_done", {31'd0, done}, 32'd0);
        check_val("t6_rearm_busy", {31'd0, busy}, 32'd1);
        feed(8'd0);
        feed(8'd200);
        for (int j = 1; j < 10; j++) feed(8'(50 + j));
        check_val("t6_cap_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("t6_rst_busy", {31'd0, busy}, 32'd0);
        check_val("t6_rst_done", {31'd0, done}, 32'd0);
        feed(8'd0); feed(8'd200); feed(8'd201);
        check_val("t6_idle_busy", {31'd0, busy}, 32'd0);
        ramp_sb();
        sb[0] = 8'd200;
        for (int j = 1; j < 10; j++) sb[j] = 8'(50 + j);
        readback("t6_mem");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
